// File: rtl/naive_bus_arbiter.sv
// Shares one naive_bus slave port among NM masters, round-robin or fixed priority.
// Read data is steered back to the master that won the read grant one cycle earlier.
module naive_bus_arbiter #(
    parameter int NM         = 3,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NM-1:0]    m_rd_req,
    input  logic [NM*4-1:0]  m_rd_be,
    input  logic [NM*32-1:0] m_rd_addr,
    output logic [NM-1:0]    m_rd_gnt,
    output logic [NM*32-1:0] m_rd_data,
    input  logic [NM-1:0]    m_wr_req,
    input  logic [NM*4-1:0]  m_wr_be,
    input  logic [NM*32-1:0] m_wr_addr,
    input  logic [NM*32-1:0] m_wr_data,
    output logic [NM-1:0]    m_wr_gnt,
    output logic             s_rd_req,
    output logic [3:0]       s_rd_be,
    output logic [31:0]      s_rd_addr,
    input  logic             s_rd_gnt,
    input  logic [31:0]      s_rd_data,
    output logic             s_wr_req,
    output logic [3:0]       s_wr_be,
    output logic [31:0]      s_wr_addr,
    output logic [31:0]      s_wr_data,
    input  logic             s_wr_gnt
);

    localparam int IW = (NM > 1) ? $clog2(NM) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] rd_own_q, rd_own_d;
    logic          rd_pend_q, rd_pend_d;

    logic [NM-1:0] req;
    logic [IW-1:0] cand;
    logic [IW-1:0] winner;
    logic          winner_vld;
    logic [IW-1:0] sel;
    logic          active;
    logic          rd_granted;
    logic          wr_granted;

    assign req = m_rd_req | m_wr_req;

    function automatic logic [IW-1:0] rotIndex(input logic [IW-1:0] base, input int offset);
        int k;
        k = int'(base) + offset;
        if (k >= NM) k = k - NM;
        return IW'(k);
    endfunction

    // Scan candidates in priority order; the first requester found wins.
    always_comb begin
        cand       = '0;
        winner     = '0;
        winner_vld = 1'b0;
        for (int i = 0; i < NM; i++) begin
            cand = FIXED_PRIO ? IW'(i) : rotIndex(rr_ptr_q, i);
            if (!winner_vld && req[cand]) begin
                winner     = cand;
                winner_vld = 1'b1;
            end
        end
    end

    // A HOLD owner that drops its request forwards nothing and releases the bus.
    always_comb begin
        if (state_q == IDLE) begin
            sel    = winner;
            active = winner_vld;
        end else begin
            sel    = owner_q;
            active = req[owner_q];
        end
        if (rst) active = 1'b0;
    end

    always_comb begin
        s_rd_req  = 1'b0;
        s_rd_be   = '0;
        s_rd_addr = '0;
        s_wr_req  = 1'b0;
        s_wr_be   = '0;
        s_wr_addr = '0;
        s_wr_data = '0;
        for (int i = 0; i < NM; i++) begin
            if (active && sel == IW'(i)) begin
                if (m_rd_req[i]) begin
                    s_rd_req  = 1'b1;
                    s_rd_be   = m_rd_be[4*i +: 4];
                    s_rd_addr = m_rd_addr[32*i +: 32];
                end else begin
                    s_wr_req  = 1'b1;
                    s_wr_be   = m_wr_be[4*i +: 4];
                    s_wr_addr = m_wr_addr[32*i +: 32];
                    s_wr_data = m_wr_data[32*i +: 32];
                end
            end
        end
    end

    assign rd_granted = s_rd_req & s_rd_gnt;
    assign wr_granted = s_wr_req & s_wr_gnt;

    always_comb begin
        m_rd_gnt  = '0;
        m_wr_gnt  = '0;
        m_rd_data = '0;
        for (int i = 0; i < NM; i++) begin
            if (sel == IW'(i)) begin
                m_rd_gnt[i] = rd_granted;
                m_wr_gnt[i] = wr_granted;
            end
            if (rd_pend_q && !rst && rd_own_q == IW'(i)) begin
                m_rd_data[32*i +: 32] = s_rd_data;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        rd_pend_d = rd_granted;
        rd_own_d  = rd_granted ? sel : rd_own_q;
        case (state_q)
            IDLE: begin
                if (active && !(rd_granted || wr_granted)) begin
                    state_d = HOLD;
                    owner_d = winner;
                end
            end
            HOLD: begin
                if (rd_granted || wr_granted || !req[owner_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rd_granted || wr_granted) begin
            rr_ptr_d = (sel == IW'(NM-1)) ? '0 : sel + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            rd_own_q  <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            rd_own_q  <= rd_own_d;
            rd_pend_q <= rd_pend_d;
        end
    end

endmodule

// File: tb/tb_naive_bus_arbiter.sv
// Scoreboard bench for naive_bus_arbiter: directed master/slave vectors, grants and
// returned read data are checked by a monitor against queued expectations.
module tb_naive_bus_arbiter;

    localparam int NM = 3;

    typedef struct packed {
        logic [NM-1:0] rdGnt;
        logic [NM-1:0] wrGnt;
        logic [31:0]   addr;
        logic [3:0]    be;
        logic [31:0]   wdata;
    } grantExp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [NM-1:0]    mRdReq, mWrReq, mRdGnt, mWrGnt;
    logic [NM*4-1:0]  mRdBe, mWrBe;
    logic [NM*32-1:0] mRdAddr, mWrAddr, mWrData, mRdData;
    logic             sRdReq, sRdGnt, sWrReq, sWrGnt;
    logic [3:0]       sRdBe, sWrBe;
    logic [31:0]      sRdAddr, sRdData, sWrAddr, sWrData;

    logic [NM-1:0]    fpWrReq, fpRdGnt, fpWrGnt;
    logic [NM*32-1:0] fpRdData;
    logic             fpSRdReq, fpSWrReq, fpSWrGnt;
    logic [3:0]       fpSRdBe, fpSWrBe;
    logic [31:0]      fpSRdAddr, fpSWrAddr, fpSWrData;

    grantExp_t        expGrantQ[$];
    logic [NM*32-1:0] expDataQ[$];
    int checks = 0;
    int passed = 0;
    logic prevRdGnt = 1'b0;

    naive_bus_arbiter #(.NM(NM), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst),
        .m_rd_req(mRdReq), .m_rd_be(mRdBe), .m_rd_addr(mRdAddr),
        .m_rd_gnt(mRdGnt), .m_rd_data(mRdData),
        .m_wr_req(mWrReq), .m_wr_be(mWrBe), .m_wr_addr(mWrAddr),
        .m_wr_data(mWrData), .m_wr_gnt(mWrGnt),
        .s_rd_req(sRdReq), .s_rd_be(sRdBe), .s_rd_addr(sRdAddr),
        .s_rd_gnt(sRdGnt), .s_rd_data(sRdData),
        .s_wr_req(sWrReq), .s_wr_be(sWrBe), .s_wr_addr(sWrAddr),
        .s_wr_data(sWrData), .s_wr_gnt(sWrGnt)
    );

    naive_bus_arbiter #(.NM(NM), .FIXED_PRIO(1'b1)) dutFixed (
        .clk(clk), .rst(rst),
        .m_rd_req('0), .m_rd_be('0), .m_rd_addr('0),
        .m_rd_gnt(fpRdGnt), .m_rd_data(fpRdData),
        .m_wr_req(fpWrReq), .m_wr_be(mWrBe), .m_wr_addr(mWrAddr),
        .m_wr_data(mWrData), .m_wr_gnt(fpWrGnt),
        .s_rd_req(fpSRdReq), .s_rd_be(fpSRdBe), .s_rd_addr(fpSRdAddr),
        .s_rd_gnt(1'b0), .s_rd_data('0),
        .s_wr_req(fpSWrReq), .s_wr_be(fpSWrBe), .s_wr_addr(fpSWrAddr),
        .s_wr_data(fpSWrData), .s_wr_gnt(fpSWrGnt)
    );

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic grantExp_t expGrant(input logic isRd, input int idx);
        grantExp_t e;
        e = '0;
        if (isRd) begin
            e.rdGnt[idx] = 1'b1;
            e.addr       = mRdAddr[32*idx +: 32];
            e.be         = mRdBe[4*idx +: 4];
        end else begin
            e.wrGnt[idx] = 1'b1;
            e.addr       = mWrAddr[32*idx +: 32];
            e.be         = mWrBe[4*idx +: 4];
            e.wdata      = mWrData[32*idx +: 32];
        end
        return e;
    endfunction

    function automatic logic [NM*32-1:0] dataVec(input int idx, input logic [31:0] d);
        logic [NM*32-1:0] v;
        v = '0;
        v[32*idx +: 32] = d;
        return v;
    endfunction

    // Monitor: pops an expectation whenever a grant or returned read data appears.
    always @(negedge clk) begin
        grantExp_t act;
        grantExp_t exp;
        if (rst) begin
            prevRdGnt = 1'b0;
        end else begin
            if (prevRdGnt) begin
                if (expDataQ.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL rdData: got 0x%0h with no expectation queued", mRdData);
                end else begin
                    checkOutput("rdData", mRdData, expDataQ.pop_front());
                end
            end else begin
                checkOutput("rdDataIdle", mRdData, '0);
            end
            if (|(mRdGnt | mWrGnt)) begin
                act.rdGnt = mRdGnt;
                act.wrGnt = mWrGnt;
                act.addr  = (|mRdGnt) ? sRdAddr : sWrAddr;
                act.be    = (|mRdGnt) ? sRdBe : sWrBe;
                act.wdata = (|mRdGnt) ? 32'h0 : sWrData;
                if (expGrantQ.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL grant: got 0x%0h with no grant expected", act);
                end else begin
                    exp = expGrantQ.pop_front();
                    checkOutput("grant", act, exp);
                end
            end
            prevRdGnt = |mRdGnt;
        end
    end

    task automatic applyStimulus(input logic r, input logic [NM-1:0] rdReq, input logic [NM-1:0] wrReq,
                                 input logic rg, input logic wg, input logic [31:0] rdata);
        @(posedge clk);
        #1;
        rst    = r;
        mRdReq = rdReq;
        mWrReq = wrReq;
        sRdGnt = rg;
        sWrGnt = wg;
        sRdData = rdata;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        mRdAddr  = {32'h0000_0100, 32'h0000_0020, 32'h0000_0010};
        mRdBe    = {4'hC, 4'h3, 4'hF};
        mWrAddr  = {32'h0000_1008, 32'h0000_1004, 32'h0000_1000};
        mWrBe    = {4'h8, 4'h6, 4'h1};
        mWrData  = {32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
        mRdReq   = '0;
        mWrReq   = '0;
        sRdGnt   = 1'b0;
        sWrGnt   = 1'b0;
        sRdData  = '0;
        fpWrReq  = '0;
        fpSWrGnt = 1'b0;

        // Reset with every master requesting and the slave granting: nothing may leak.
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b1, 3'b111, 3'b111, 1'b1, 1'b1, 32'hDEAD_BEEF);
            checkOutput("rstSRdReq", sRdReq, 1'b0);
            checkOutput("rstSWrReq", sWrReq, 1'b0);
            checkOutput("rstGnt", {mRdGnt, mWrGnt}, '0);
            checkOutput("rstRdData", mRdData, '0);
        end

        // Single read by master 2, immediate grant, data next cycle.
        expGrantQ.push_back(expGrant(1'b1, 2));
        expDataQ.push_back(dataVec(2, 32'h928C_D0F1));
        applyStimulus(1'b0, 3'b100, 3'b000, 1'b1, 1'b0, 32'h0);
        checkOutput("singleRdGnt", mRdGnt, 3'b100);
        applyStimulus(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 32'h928C_D0F1);
        applyStimulus(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 32'h0);

        // Round-robin over three writers, pointer wraps 2 -> 0.
        for (int c = 0; c < 6; c++) expGrantQ.push_back(expGrant(1'b0, c % NM));
        for (int c = 0; c < 6; c++) applyStimulus(1'b0, 3'b000, 3'b111, 1'b0, 1'b1, 32'h0);
        applyStimulus(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 32'h0);

        // HOLD: master 1 owns the slave while grant is withheld; master 0 waits.
        applyStimulus(1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 32'h0);
        checkOutput("holdAddr0", {sRdReq, sRdAddr}, {1'b1, 32'h0000_0020});
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 3'b011, 3'b000, 1'b0, 1'b0, 32'h0);
            checkOutput("holdAddr", {sRdReq, sRdAddr}, {1'b1, 32'h0000_0020});
        end
        expGrantQ.push_back(expGrant(1'b1, 1));
        expDataQ.push_back(dataVec(1, 32'hB1B1_B1B1));
        applyStimulus(1'b0, 3'b011, 3'b000, 1'b1, 1'b0, 32'h0);
        expGrantQ.push_back(expGrant(1'b1, 0));
        expDataQ.push_back(dataVec(0, 32'hA0A0_A0A0));
        applyStimulus(1'b0, 3'b001, 3'b000, 1'b1, 1'b0, 32'hB1B1_B1B1);
        applyStimulus(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 32'hA0A0_A0A0);

        // Back-to-back reads to different masters route each word correctly.
        expGrantQ.push_back(expGrant(1'b1, 0));
        expDataQ.push_back(dataVec(0, 32'h0000_000A));
        applyStimulus(1'b0, 3'b001, 3'b000, 1'b1, 1'b0, 32'h0);
        expGrantQ.push_back(expGrant(1'b1, 1));
        expDataQ.push_back(dataVec(1, 32'h0000_000B));
        applyStimulus(1'b0, 3'b010, 3'b000, 1'b1, 1'b0, 32'h0000_000A);
        applyStimulus(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 32'h0000_000B);

        // Master 2 asks for read and write together: read first, write later.
        expGrantQ.push_back(expGrant(1'b1, 2));
        expDataQ.push_back(dataVec(2, 32'h55AA_55AA));
        applyStimulus(1'b0, 3'b100, 3'b100, 1'b1, 1'b1, 32'h0);
        expGrantQ.push_back(expGrant(1'b0, 2));
        applyStimulus(1'b0, 3'b000, 3'b100, 1'b0, 1'b1, 32'h55AA_55AA);
        applyStimulus(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 32'h0);

        // HOLD owner drops its request: no grant, pointer stays at 0.
        applyStimulus(1'b0, 3'b000, 3'b010, 1'b0, 1'b0, 32'h0);
        checkOutput("dropHoldFwd", {sWrReq, sWrAddr}, {1'b1, 32'h0000_1004});
        applyStimulus(1'b0, 3'b000, 3'b101, 1'b0, 1'b1, 32'h0);
        checkOutput("dropNoFwd", {sWrReq, sRdReq}, 2'b00);
        expGrantQ.push_back(expGrant(1'b0, 0));
        applyStimulus(1'b0, 3'b000, 3'b101, 1'b0, 1'b1, 32'h0);
        applyStimulus(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 32'h0);

        // Reset while master 1 holds the slave: request dropped, pointer back to 0.
        applyStimulus(1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 32'h0);
        checkOutput("preRstHold", {sRdReq, sRdAddr}, {1'b1, 32'h0000_0020});
        applyStimulus(1'b1, 3'b010, 3'b000, 1'b1, 1'b0, 32'h0);
        checkOutput("rstHoldSRdReq", sRdReq, 1'b0);
        checkOutput("rstHoldGnt", {mRdGnt, mWrGnt}, '0);
        expGrantQ.push_back(expGrant(1'b1, 0));
        expDataQ.push_back(dataVec(0, 32'h1234_5678));
        applyStimulus(1'b0, 3'b011, 3'b000, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 32'h1234_5678);
        applyStimulus(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 32'h0);

        // Fixed priority: master 0 starves master 2 until it stops requesting.
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            fpWrReq  = 3'b101;
            fpSWrGnt = 1'b1;
            @(negedge clk);
            checkOutput("fixedGnt", {fpWrGnt, fpSWrAddr}, {3'b001, 32'h0000_1000});
        end
        @(posedge clk);
        #1;
        fpWrReq = 3'b100;
        @(negedge clk);
        checkOutput("fixedLow", {fpWrGnt, fpSWrAddr}, {3'b100, 32'h0000_1008});
        @(posedge clk);
        #1;
        fpWrReq  = 3'b000;
        fpSWrGnt = 1'b0;
        @(negedge clk);
        #1;

        checkOutput("grantQueueDrained", expGrantQ.size(), 0);
        checkOutput("dataQueueDrained", expDataQ.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
